// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the transmit-side glitch-filter companion (filter_tx).
//   state_e        : transmit FSM states (IDLE, HOLD)
//   FILTER_TAPS    : sample depth of the downstream receive filter
//   LFSR_W         : width of the optional glitch LFSR
//   LFSR_TAP_MASK  : Fibonacci taps 8,6,5,4 expressed as a bit mask
//   hold_cycles_ok : elaboration-time check that a symbol outlasts the filter
// -----------------------------------------------------------------------------
package filter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int FILTER_TAPS = 3;
  localparam int LFSR_W      = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 8'hB8;

  // A symbol must stay on the line for at least one cycle more than the
  // receive filter needs to see it settled. The hold counter is 8 bits wide.
  function automatic bit hold_cycles_ok(input int hold);
    return (hold >= FILTER_TAPS + 1) && (hold <= 255);
  endfunction

endpackage

// File: rtl/filter_tx_fifo.sv
// -----------------------------------------------------------------------------
// filter_tx_fifo
// Single-clock synchronous FIFO of 1-bit symbols with occupancy count.
// A push while full is dropped even when a pop happens on the same edge.
// Ports:
//   clock, reset     : clock and synchronous active-high reset
//   push_i, wr_data_i: write request and data
//   pop_i, rd_data_o : read request and head-of-queue data (valid when !empty)
//   full_o, empty_o  : occupancy flags
//   level_o          : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module filter_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       wr_data_i,
  input  logic                       pop_i,
  output logic                       rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic          mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rptr_q];

  // Full wins over a simultaneous pop: no same-cycle bypass into a full queue.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage carries no reset; only the pointers define what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clock) begin
      if (push_ok && (wptr_q == AW'(gi))) begin
        mem_q[gi] <= wr_data_i;
      end
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/filter_tx.sv
// -----------------------------------------------------------------------------
// filter_tx
// Transmit-side companion to the receive glitch filter. Symbols accepted over a
// valid/ready handshake are queued and each is held on sig_out for HOLD_CYCLES
// cycles, back-to-back while the queue has data.
// Optional build macro: FILTER_TX_GLITCH_EN adds glitch_en and an 8-bit LFSR
// that injects single-cycle mid-symbol inversions to exercise the receiver.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bit_in       : symbol to transmit
//   bit_valid    : bit_in valid this cycle
//   glitch_en    : (FILTER_TX_GLITCH_EN only) enable mid-symbol glitches
//   bit_ready    : queue can accept (not full)
//   sig_out      : registered line level
//   busy         : FSM not IDLE or queue non-empty
//   level        : queue occupancy
// -----------------------------------------------------------------------------
module filter_tx
  import filter_pkg::*;
#(
  parameter int          HOLD_CYCLES = 6,
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       bit_in,
  input  logic                       bit_valid,
`ifdef FILTER_TX_GLITCH_EN
  input  logic                       glitch_en,
`endif
  output logic                       bit_ready,
  output logic                       sig_out,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  if (!hold_cycles_ok(HOLD_CYCLES)) begin : g_bad_hold
    $error("filter_tx: HOLD_CYCLES out of range");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("filter_tx: LFSR_SEED must be non-zero");
  end

  localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sym_q, sym_d;     // symbol value without any injected glitch
  logic       line_q, line_d;   // what actually drives the line
  logic       glitch_d;
  logic       fifo_pop;
  logic       fifo_rd_data;
  logic       fifo_full;
  logic       fifo_empty;

  filter_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (bit_valid),
    .wr_data_i (bit_in),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sym_d    = fifo_rd_data;
          cnt_d    = CNT_LOAD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!fifo_empty) begin
          // Next symbol starts on the very next cycle: no gap on the line.
          fifo_pop = 1'b1;
          sym_d    = fifo_rd_data;
          cnt_d    = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FILTER_TX_GLITCH_EN
  localparam logic [7:0] CNT_MID = 8'(HOLD_CYCLES / 2);

  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_fb;

  assign lfsr_fb = ^(lfsr_q & LFSR_TAP_MASK);

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_fb};
  end

  // CNT_MID lies strictly between CNT_LOAD and 0 for HOLD_CYCLES >= 4, so a
  // glitch can never land on a symbol's first or last cycle.
  assign glitch_d = (state_d == HOLD) && glitch_en && (cnt_d == CNT_MID) && lfsr_q[0];
`else
  assign glitch_d = 1'b0;
`endif

  assign line_d = sym_d ^ glitch_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sym_q   <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      line_q  <= line_d;
    end
  end

  assign sig_out   = line_q;
  assign bit_ready = ~fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule
